// File: rtl/tensor_core_pkg.sv
// Shared defaults, FSM state type and FP16 encoding constants for the
// tensor-core accumulator resolve path.
package tensor_core_pkg;

  localparam int TILE_NUM   = 4;
  localparam int FP_DWIDTH  = 16;
  localparam int FP_EWIDTH  = 5;
  localparam int FP_MWIDTH  = 10;
  localparam int ACC_AWIDTH = 92;
  localparam int ACC_FWIDTH = 48;

  localparam logic [15:0] FP16_INF  = 16'h7C00;
  localparam int          FP16_BIAS = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tensor_core_acc2fp16.sv
// Combinational conversion of one carry-save fixed-point accumulator
// element into FP16 with round-to-nearest-even and saturation to Inf.
module tensor_core_acc2fp16
  import tensor_core_pkg::*;
#(
  parameter int DWIDTH = FP_DWIDTH,
  parameter int EWIDTH = FP_EWIDTH,
  parameter int MWIDTH = FP_MWIDTH,
  parameter int AWIDTH = ACC_AWIDTH,
  parameter int FWIDTH = ACC_FWIDTH
) (
  input  logic [AWIDTH-1:0] sum,
  input  logic [AWIDTH-1:0] carry,
  output logic [DWIDTH-1:0] fp
);

  localparam logic [AWIDTH-1:0] ONE   = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] INF_W = AWIDTH'(((1 << EWIDTH) - 1) << MWIDTH);

  logic [AWIDTH-1:0] v;
  logic [AWIDTH-1:0] mag;
  logic [AWIDTH-1:0] sh;
  logic [AWIDTH-1:0] mask;
  logic [AWIDTH-1:0] code;
  logic              sign;
  logic              guard;
  logic              sticky;
  logic              rnd_up;
  int                lzc;
  int                be;
  int                lsb;

  // Resolve, take magnitude, normalise and round. The biased exponent is
  // clamped at 1 so subnormals share the normal datapath: the kept LSB then
  // sits at weight 2^-24, and adding the rounded significand onto
  // (be-1)<<MWIDTH lets a mantissa carry bump the exponent for free.
  always_comb begin
    v    = sum + carry;
    sign = v[AWIDTH-1];
    mag  = sign ? (~v + ONE) : v;
    lzc  = AWIDTH;
    for (int i = 0; i < AWIDTH; i++) begin
      if (mag[i]) lzc = AWIDTH - 1 - i;
    end
    be = (AWIDTH - 1 - lzc) - FWIDTH + FP16_BIAS;
    if (be < 1) be = 1;
    lsb    = be + FWIDTH - FP16_BIAS - MWIDTH;
    sh     = mag >> (lsb - 1);
    mask   = (ONE << (lsb - 1)) - ONE;
    guard  = sh[0];
    sticky = |(mag & mask);
    rnd_up = guard & (sticky | sh[1]);
    code   = (AWIDTH'(be - 1) << MWIDTH) + (sh >> 1) + AWIDTH'(rnd_up);
    if (code >= INF_W) fp = {sign, INF_W[DWIDTH-2:0]};
    else               fp = {sign, code[DWIDTH-2:0]};
  end

endmodule

// File: rtl/tensor_core_acc_resolve.sv
// Resolves a latched NUM x NUM carry-save accumulator tile into FP16,
// one element per cycle through a single shared converter.
module tensor_core_acc_resolve
  import tensor_core_pkg::*;
#(
  parameter int NUM    = TILE_NUM,
  parameter int DWIDTH = FP_DWIDTH,
  parameter int EWIDTH = FP_EWIDTH,
  parameter int MWIDTH = FP_MWIDTH,
  parameter int AWIDTH = ACC_AWIDTH,
  parameter int FWIDTH = ACC_FWIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM-1:0][NUM-1:0][AWIDTH-1:0] C_sum_in,
  input  logic [NUM-1:0][NUM-1:0][AWIDTH-1:0] C_carry_in,
  input  logic                                 C_valid_in,
  output logic                                 C_ready_out,
  output logic [NUM-1:0][NUM-1:0][DWIDTH-1:0] D_out,
  output logic                                 D_valid_out,
  input  logic                                 D_ready_in
);

  localparam int ELEMS = NUM * NUM;
  localparam int SEL_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int CNT_W = $clog2(ELEMS + 1);
  localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(ELEMS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(ELEMS - 1);

  state_t                        state_reg;
  state_t                        state_next;
  logic [CNT_W-1:0]              idx_reg;
  logic [SEL_W-1:0]              sel;
  logic [ELEMS-1:0][AWIDTH-1:0]  sum_lat_reg;
  logic [ELEMS-1:0][AWIDTH-1:0]  carry_lat_reg;
  logic [DWIDTH-1:0]             conv_fp;
  logic [DWIDTH-1:0]             fp_reg;
  logic [SEL_W-1:0]              wr_idx_reg;
  logic                          wr_vld_reg;
  logic                          accept;
  logic                          issue;
  logic                          last_write;
  logic [ELEMS-1:0][DWIDTH-1:0]  d_flat;

  assign C_ready_out = (state_reg == IDLE);
  assign D_valid_out = (state_reg == DONE);
  assign accept      = C_valid_in & C_ready_out;
  assign issue       = (state_reg == RUN) && (idx_reg != END_CNT);
  assign last_write  = wr_vld_reg && (wr_idx_reg == LAST_SEL);
  assign sel         = idx_reg[SEL_W-1:0];
  assign D_out       = d_flat;

  // Next-state logic: leave RUN once the last element lands in D_out.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_write) state_next = DONE;
      DONE:    if (D_ready_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Capture the whole input tile on accept and hold it until the next one.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      sum_lat_reg   <= C_sum_in;
      carry_lat_reg <= C_carry_in;
    end
  end

  // Element sequencer plus one register stage after the long converter path.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg    <= '0;
      wr_vld_reg <= 1'b0;
      wr_idx_reg <= '0;
      fp_reg     <= '0;
    end else begin
      wr_vld_reg <= issue;
      if (issue) begin
        fp_reg     <= conv_fp;
        wr_idx_reg <= sel;
        idx_reg    <= idx_reg + CNT_W'(1);
      end else if (state_reg != RUN) begin
        idx_reg <= '0;
      end
    end
  end

  tensor_core_acc2fp16 #(
    .DWIDTH (DWIDTH),
    .EWIDTH (EWIDTH),
    .MWIDTH (MWIDTH),
    .AWIDTH (AWIDTH),
    .FWIDTH (FWIDTH)
  ) u_conv (
    .sum   (sum_lat_reg[sel]),
    .carry (carry_lat_reg[sel]),
    .fp    (conv_fp)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ELEMS; gi++) begin : g_elem
      logic [DWIDTH-1:0] elem_reg;
      // Drop the registered conversion result into its row-major slot.
      always_ff @(posedge clk) begin
        if (rst) elem_reg <= '0;
        else if (wr_vld_reg && (wr_idx_reg == SEL_W'(gi))) elem_reg <= fp_reg;
      end
      assign d_flat[gi] = elem_reg;
    end
  endgenerate

endmodule
